// File: rtl/hamming_pkg.sv
// Shared Hamming code helpers used by the stream decoder and the matching encoder.
//   calc_par_w  : number of Hamming parity bits needed for a given data width
//   calc_code_w : full codeword width, including the optional overall-parity bit
//   h_column    : parity-check column assigned to data bit d
//   decode_status_e : classification of one decoded word
package hamming_pkg;

    // Largest parity width reachable for the supported data range (57 data bits).
    localparam int MAX_PAR_W = 6;

    typedef enum logic [1:0] {
        ST_CLEAN         = 2'd0,
        ST_CORRECTED     = 2'd1,
        ST_UNCORRECTABLE = 2'd2
    } decode_status_e;

    // Smallest R with 2^R - R - 1 >= data_w. Scanning downwards lets the
    // smallest qualifying R overwrite any larger one.
    function automatic int calc_par_w(input int data_w);
        int r;
        r = MAX_PAR_W + 1;
        for (int k = MAX_PAR_W + 1; k >= 1; k--) begin
            if (((1 << k) - k - 1) >= data_w) begin
                r = k;
            end
        end
        return r;
    endfunction

    function automatic int calc_code_w(input int data_w, input int secded);
        return data_w + calc_par_w(data_w) + ((secded != 0) ? 1 : 0);
    endfunction

    function automatic int count_ones(input int value);
        int n;
        n = 0;
        for (int i = 0; i < 32; i++) begin
            n += (value >> i) & 1;
        end
        return n;
    endfunction

    // Data bit d takes entry (data_w-1-d) of the descending list of par_w-bit
    // values with at least two ones; single-one values belong to parity bits.
    function automatic int h_column(input int data_w, input int d);
        int par_w;
        int idx;
        int seen;
        int result;
        par_w  = calc_par_w(data_w);
        idx    = data_w - 1 - d;
        seen   = 0;
        result = 0;
        for (int v = (1 << par_w) - 1; v > 0; v--) begin
            if (count_ones(v) >= 2) begin
                if (seen == idx && result == 0) begin
                    result = v;
                end
                seen++;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/hamming_stream_decoder_if.sv
// Valid/ready stream bundle for the Hamming decoder.
//   in_valid/in_ready/in_code                     : codeword input stream
//   out_valid/out_ready/out_data                  : decoded data output stream
//   out_corrected/out_uncorrectable               : per-word status flags
// modport slave  : the decoder side
// modport master : the producer/consumer side driving the decoder
interface hamming_stream_decoder_if
    import hamming_pkg::*;
#(
    parameter int DATA_W = 4,
    parameter int SECDED = 0
);
    localparam int CODE_W = calc_code_w(DATA_W, SECDED);

    logic              in_valid;
    logic              in_ready;
    logic [CODE_W-1:0] in_code;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_corrected;
    logic              out_uncorrectable;

    modport slave (
        input  in_valid, in_code, out_ready,
        output in_ready, out_valid, out_data, out_corrected, out_uncorrectable
    );

    modport master (
        output in_valid, in_code, out_ready,
        input  in_ready, out_valid, out_data, out_corrected, out_uncorrectable
    );

endinterface

// File: rtl/hamming_syndrome.sv
// Combinational syndrome generator (decoder stage 1 logic).
//   code       : received codeword (data MSB-first above the parity bits,
//                optional overall-parity bit on top)
//   syndrome   : XOR of the H-columns of all set data/parity bits
//   parity_odd : XOR of the whole codeword when SECDED is enabled, else 0
module hamming_syndrome
    import hamming_pkg::*;
#(
    parameter int DATA_W = 4,
    parameter int SECDED = 0,
    localparam int PAR_W  = calc_par_w(DATA_W),
    localparam int CODE_W = calc_code_w(DATA_W, SECDED)
) (
    input  logic [CODE_W-1:0] code,
    output logic [PAR_W-1:0]  syndrome,
    output logic              parity_odd
);

    always_comb begin
        syndrome = '0;
        for (int j = 0; j < PAR_W; j++) begin
            if (code[j]) begin
                syndrome ^= PAR_W'(1 << j);
            end
        end
        for (int d = 0; d < DATA_W; d++) begin
            if (code[PAR_W + d]) begin
                syndrome ^= PAR_W'(h_column(DATA_W, d));
            end
        end
    end

    assign parity_odd = (SECDED != 0) ? ^code : 1'b0;

endmodule

// File: rtl/hamming_stream_decoder.sv
// Two-stage pipelined Hamming SEC / SECDED stream decoder.
//   clk, rst          : single rising-edge clock, synchronous active-high reset
//   bus (slave)       : input codeword stream and decoded output stream
//   cnt_clr           : clears both error counters (wins over an increment)
//   corr_cnt          : delivered words flagged corrected (saturating)
//   uncorr_cnt        : delivered words flagged uncorrectable (saturating)
// Both stages advance together on en = !out_valid || out_ready, so a stalled
// output freezes the whole pipe and nothing is dropped or duplicated.
module hamming_stream_decoder
    import hamming_pkg::*;
#(
    parameter int DATA_W = 4,
    parameter int SECDED = 0,
    parameter int CNT_W  = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    hamming_stream_decoder_if.slave bus,
    input  logic                   cnt_clr,
    output logic [CNT_W-1:0]       corr_cnt,
    output logic [CNT_W-1:0]       uncorr_cnt
);

    localparam int PAR_W = calc_par_w(DATA_W);

    logic              en;
    logic [PAR_W-1:0]  syn_c;
    logic              odd_c;

    logic              s1_valid;
    logic [PAR_W-1:0]  s1_syn;
    logic              s1_odd;
    logic [DATA_W-1:0] s1_data;

    logic [DATA_W-1:0] fixed_data;
    logic              match_data;
    decode_status_e    status;
    logic              out_xfer;

    assign en           = !bus.out_valid || bus.out_ready;
    assign bus.in_ready = en && !rst;
    assign out_xfer     = bus.out_valid && bus.out_ready;

    hamming_syndrome #(
        .DATA_W (DATA_W),
        .SECDED (SECDED)
    ) u_syndrome (
        .code       (bus.in_code),
        .syndrome   (syn_c),
        .parity_odd (odd_c)
    );

    // Stage 2 combinational correction.
    // NOTE: every variable gets a default at the top of always_comb so no path
    // leaves it unassigned; otherwise synthesis infers a latch.
    always_comb begin
        fixed_data = s1_data;
        match_data = 1'b0;
        status     = ST_CLEAN;
        for (int d = 0; d < DATA_W; d++) begin
            if (s1_syn == PAR_W'(h_column(DATA_W, d))) begin
                fixed_data[d] = ~s1_data[d];
                match_data    = 1'b1;
            end
        end
        if (s1_syn == '0) begin
            // Zero syndrome with odd overall parity: only the overall bit flipped.
            status = (SECDED != 0 && s1_odd) ? ST_CORRECTED : ST_CLEAN;
        end else if (SECDED != 0 && !s1_odd) begin
            // Nonzero syndrome with even overall parity: a double error.
            status = ST_UNCORRECTABLE;
        end else if (match_data || $onehot(s1_syn)) begin
            status = ST_CORRECTED;
        end else begin
            status = ST_UNCORRECTABLE;
        end
        // Uncorrectable words pass the raw received data through.
        if (status == ST_UNCORRECTABLE) begin
            fixed_data = s1_data;
        end
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of statement order.
    // NOTE: the payload registers are reset along with the valids because the
    // outputs must read zero after reset, not just be marked invalid.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid              <= 1'b0;
            s1_syn                <= '0;
            s1_odd                <= 1'b0;
            s1_data               <= '0;
            bus.out_valid         <= 1'b0;
            bus.out_data          <= '0;
            bus.out_corrected     <= 1'b0;
            bus.out_uncorrectable <= 1'b0;
        end else if (en) begin
            s1_valid              <= bus.in_valid;
            s1_syn                <= syn_c;
            s1_odd                <= odd_c;
            s1_data               <= bus.in_code[DATA_W+PAR_W-1:PAR_W];
            bus.out_valid         <= s1_valid;
            bus.out_data          <= fixed_data;
            bus.out_corrected     <= s1_valid && (status == ST_CORRECTED);
            bus.out_uncorrectable <= s1_valid && (status == ST_UNCORRECTABLE);
        end
    end

    // Error counters count delivered words only and stick at all-ones.
    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            corr_cnt   <= '0;
            uncorr_cnt <= '0;
        end else if (out_xfer) begin
            if (bus.out_corrected && corr_cnt != '1) begin
                corr_cnt <= corr_cnt + CNT_W'(1);
            end
            if (bus.out_uncorrectable && uncorr_cnt != '1) begin
                uncorr_cnt <= uncorr_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_hamming_stream_decoder.sv
// Self-checking bench for hamming_stream_decoder. Three decoder instances:
//   inst 0: DATA_W=4, SECDED=0, CNT_W=16
//   inst 1: DATA_W=4, SECDED=1, CNT_W=16
//   inst 2: DATA_W=8, SECDED=0, CNT_W=2
// The reference model decodes by nearest-codeword search: a word is valid if
// it equals the encoding of its own data bits; otherwise any single bit flip
// that yields a valid word is the correction, and if none does the word is
// uncorrectable.
module tb_hamming_stream_decoder;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [2:0]       iv, ordy, clr;
    logic [2:0][63:0] ic;
    logic [2:0]       ir, ov, oc, ou;
    logic [2:0][63:0] od;
    logic [2:0][15:0] cc, uc;

    int n_tests = 0;
    int n_fail  = 0;
    bit done;

    // ---------------- reference helpers ----------------
    function automatic int dw_of(input int g);
        return (g == 2) ? 8 : 4;
    endfunction
    function automatic int sec_of(input int g);
        return (g == 1) ? 1 : 0;
    endfunction
    function automatic int cntw_of(input int g);
        return (g == 2) ? 2 : 16;
    endfunction
    function automatic int pw_of(input int dw);
        int r;
        r = 1;
        while (((1 << r) - r - 1) < dw) r++;
        return r;
    endfunction
    function automatic int cw_of(input int g);
        return dw_of(g) + pw_of(dw_of(g)) + sec_of(g);
    endfunction
    function automatic logic [63:0] mask(input int n);
        return (64'd1 << n) - 64'd1;
    endfunction

    // k-th entry of the descending list of pw-bit values with >= 2 ones.
    function automatic int col(input int pw, input int k);
        int seen;
        int res;
        seen = 0;
        res  = 0;
        for (int v = (1 << pw) - 1; v > 0; v--) begin
            if ($countones(v) >= 2) begin
                if (seen == k) res = v;
                seen++;
            end
        end
        return res;
    endfunction

    function automatic logic [63:0] encode(input int dw, input int sec, input logic [63:0] data);
        int pw;
        logic [63:0] par;
        logic [63:0] code;
        pw   = pw_of(dw);
        data = data & mask(dw);
        par  = 64'd0;
        for (int d = 0; d < dw; d++) begin
            if (data[d]) par ^= 64'(col(pw, dw - 1 - d));
        end
        code = (data << pw) | par;
        if (sec != 0) code |= 64'(^code) << (dw + pw);
        return code;
    endfunction

    function automatic bit is_codeword(input int dw, input int sec, input logic [63:0] code);
        int pw;
        pw = pw_of(dw);
        return code == encode(dw, sec, (code >> pw) & mask(dw));
    endfunction

    function automatic void model(input int dw, input int sec, input logic [63:0] code,
                                  output logic [63:0] data, output bit corr, output bit unc);
        int pw;
        int cw;
        logic [63:0] alt;
        pw   = pw_of(dw);
        cw   = dw + pw + sec;
        code = code & mask(cw);
        data = (code >> pw) & mask(dw);
        corr = 1'b0;
        unc  = 1'b0;
        if (!is_codeword(dw, sec, code)) begin
            unc = 1'b1;
            for (int i = 0; i < cw; i++) begin
                alt = code ^ (64'd1 << i);
                if (!corr && is_codeword(dw, sec, alt)) begin
                    corr = 1'b1;
                    unc  = 1'b0;
                    data = (alt >> pw) & mask(dw);
                end
            end
        end
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- DUT instances ----------------
    for (genvar g = 0; g < 3; g++) begin : inst
        localparam int D  = dw_of(g);
        localparam int S  = sec_of(g);
        localparam int C  = cntw_of(g);
        localparam int CW = cw_of(g);

        hamming_stream_decoder_if #(.DATA_W(D), .SECDED(S)) bus ();
        logic [C-1:0] corr_cnt;
        logic [C-1:0] uncorr_cnt;

        assign bus.in_valid  = iv[g];
        assign bus.in_code   = ic[g][CW-1:0];
        assign bus.out_ready = ordy[g];
        assign ir[g] = bus.in_ready;
        assign ov[g] = bus.out_valid;
        assign od[g] = 64'(bus.out_data);
        assign oc[g] = bus.out_corrected;
        assign ou[g] = bus.out_uncorrectable;
        assign cc[g] = 16'(corr_cnt);
        assign uc[g] = 16'(uncorr_cnt);

        hamming_stream_decoder #(.DATA_W(D), .SECDED(S), .CNT_W(C)) dut (
            .clk        (clk),
            .rst        (rst),
            .bus        (bus),
            .cnt_clr    (clr[g]),
            .corr_cnt   (corr_cnt),
            .uncorr_cnt (uncorr_cnt)
        );
    end

    // ---------------- scoreboard + compare process ----------------
    logic [63:0] qd [3][64];
    bit          qc [3][64];
    bit          qu [3][64];
    int          qh [3] = '{0, 0, 0};
    int          qt [3] = '{0, 0, 0};
    int          qn [3] = '{0, 0, 0};
    int          mc [3] = '{0, 0, 0};
    int          mu [3] = '{0, 0, 0};
    bit          held [3] = '{0, 0, 0};
    logic [63:0] hd [3];
    bit          hc [3];
    bit          hu [3];

    always @(negedge clk) begin
        logic [63:0] ed;
        bit ec, eu;
        int cmax;
        for (int g = 0; g < 3; g++) begin
            cmax = (1 << cntw_of(g)) - 1;
            if (rst) check($sformatf("in_ready_in_reset[%0d]", g), 64'(ir[g]), 64'd0);
            check($sformatf("corr_cnt[%0d]", g), 64'(cc[g]), 64'(mc[g]));
            check($sformatf("uncorr_cnt[%0d]", g), 64'(uc[g]), 64'(mu[g]));
            if (held[g]) begin
                check($sformatf("stall_valid[%0d]", g), 64'(ov[g]), 64'd1);
                check($sformatf("stall_data[%0d]", g), od[g], hd[g]);
                check($sformatf("stall_flags[%0d]", g), {62'd0, oc[g], ou[g]}, {62'd0, hc[g], hu[g]});
            end
            if (ov[g]) begin
                if (qn[g] == 0) begin
                    check($sformatf("unexpected_out[%0d]", g), 64'(ov[g]), 64'd0);
                end else begin
                    check($sformatf("out_data[%0d]", g), od[g], qd[g][qh[g]]);
                    check($sformatf("out_flags[%0d]", g), {62'd0, oc[g], ou[g]},
                          {62'd0, qc[g][qh[g]], qu[g][qh[g]]});
                end
            end
            if (rst) begin
                qh[g] = 0; qt[g] = 0; qn[g] = 0;
                mc[g] = 0; mu[g] = 0; held[g] = 0;
            end else begin
                held[g] = ov[g] && !ordy[g];
                hd[g] = od[g]; hc[g] = oc[g]; hu[g] = ou[g];
                if (ov[g] && ordy[g] && qn[g] > 0) begin
                    if (qc[g][qh[g]] && mc[g] < cmax) mc[g]++;
                    if (qu[g][qh[g]] && mu[g] < cmax) mu[g]++;
                    qh[g] = (qh[g] + 1) % 64;
                    qn[g]--;
                end
                if (clr[g]) begin
                    mc[g] = 0;
                    mu[g] = 0;
                end
                if (iv[g] && ir[g]) begin
                    model(dw_of(g), sec_of(g), ic[g], ed, ec, eu);
                    qd[g][qt[g]] = ed; qc[g][qt[g]] = ec; qu[g][qt[g]] = eu;
                    qt[g] = (qt[g] + 1) % 64;
                    qn[g]++;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic send(input int g, input logic [63:0] code);
        bit acc;
        bit ok;
        ok = 1'b0;
        iv[g] = 1'b1;
        ic[g] = code;
        for (int n = 0; n < 100 && !ok; n++) begin
            @(negedge clk);
            acc = ir[g];
            @(posedge clk);
            #1;
            ok = acc;
        end
        iv[g] = 1'b0;
        if (!ok) check($sformatf("send_timeout[%0d]", g), 64'(ok), 64'd1);
    endtask

    // Requires an empty pipe and out_ready=1 on instance g.
    task automatic directed(input int g, input logic [63:0] code, input logic [63:0] ed,
                            input bit ec, input bit eu, input string nm);
        send(g, code);
        check({nm, "_valid_after_1"}, 64'(ov[g]), 64'd0);
        @(posedge clk); #1;
        check({nm, "_valid_after_2"}, 64'(ov[g]), 64'd1);
        check({nm, "_data"}, od[g], ed);
        check({nm, "_corrected"}, 64'(oc[g]), 64'(ec));
        check({nm, "_uncorrectable"}, 64'(ou[g]), 64'(eu));
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] md;
        bit mcf, muf;
        logic [63:0] c;
        int flips;

        rst = 1'b1; iv = '0; ordy = '1; clr = '0; ic = '0; done = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int g = 0; g < 3; g++) begin
            check($sformatf("rst_out_valid[%0d]", g), 64'(ov[g]), 64'd0);
            check($sformatf("rst_out_data[%0d]", g), od[g], 64'd0);
            check($sformatf("rst_flags[%0d]", g), {62'd0, oc[g], ou[g]}, 64'd0);
            check($sformatf("rst_counters[%0d]", g), {32'd0, cc[g], uc[g]}, 64'd0);
            check($sformatf("rst_in_ready[%0d]", g), 64'(ir[g]), 64'd0);
        end
        rst = 1'b0;
        @(posedge clk); #1;

        // Pin the reference model to hand-worked vectors.
        model(4, 0, 64'b0011001, md, mcf, muf);
        check("model_sec_flip6", {md[61:0], mcf, muf}, {58'd0, 4'b1011, 1'b1, 1'b0});
        model(4, 1, 64'b00111001, md, mcf, muf);
        check("model_secded_double", {md[61:0], mcf, muf}, {58'd0, 4'b0111, 1'b0, 1'b1});
        model(8, 0, 64'h006, md, mcf, muf);
        check("model_unused_col", {md[61:0], mcf, muf}, {62'd0, 1'b0, 1'b1});
        check("model_encode_a5", encode(8, 0, 64'hA5), 64'hA5F);

        directed(0, 64'b1011001, 64'b1011, 1'b0, 1'b0, "clean_sec");
        check("clean_sec_corr_cnt", 64'(cc[0]), 64'd0);
        directed(0, 64'b0011001, 64'b1011, 1'b1, 1'b0, "flip_d3_sec");
        check("flip_d3_corr_cnt", 64'(cc[0]), 64'd1);
        directed(0, 64'b1011011, 64'b1011, 1'b1, 1'b0, "flip_p1_sec");
        directed(1, 64'b00111001, 64'b0111, 1'b0, 1'b1, "double_secded");
        check("double_secded_uncorr_cnt", 64'(uc[1]), 64'd1);
        directed(1, 64'b11011001, 64'b1011, 1'b1, 1'b0, "overall_bit_secded");
        directed(2, 64'h006, 64'h00, 1'b0, 1'b1, "unused_col_d8");
        check("unused_col_uncorr_cnt", 64'(uc[2]), 64'd1);
        directed(2, 64'h85F, 64'hA5, 1'b1, 1'b0, "flip_d5_d8");
        directed(2, 64'hA5E, 64'hA5, 1'b1, 1'b0, "flip_p0_d8");

        // Saturation: two corrections already delivered, four more reach 3 and stick.
        for (int i = 0; i < 4; i++) directed(2, 64'h85F, 64'hA5, 1'b1, 1'b0, "sat");
        check("corr_cnt_saturated", 64'(cc[2]), 64'd3);

        // Clear on the same cycle as a corrected word is delivered.
        ordy[2] = 1'b0;
        send(2, 64'h85F);
        repeat (2) @(posedge clk);
        #1;
        check("clr_word_held", 64'(ov[2]), 64'd1);
        ordy[2] = 1'b1;
        clr[2] = 1'b1;
        @(posedge clk); #1;
        clr[2] = 1'b0;
        check("clr_priority_corr_cnt", 64'(cc[2]), 64'd0);
        check("clr_word_delivered", 64'(ov[2]), 64'd0);

        // Back-to-back streams with random backpressure.
        for (int g = 0; g < 3; g++) begin
            done = 1'b0;
            fork
                begin
                    for (int i = 0; i < 20; i++) begin
                        c = encode(dw_of(g), sec_of(g), 64'($urandom) << 32 | 64'($urandom));
                        flips = $urandom_range(0, 2);
                        for (int f = 0; f < flips; f++) begin
                            c ^= 64'd1 << $urandom_range(0, cw_of(g) - 1);
                        end
                        send(g, c);
                    end
                    done = 1'b1;
                end
                begin
                    while (!done) begin
                        ordy[g] = 1'($urandom_range(0, 1));
                        @(posedge clk); #1;
                    end
                end
            join
            ordy[g] = 1'b1;
            for (int n = 0; n < 40 && qn[g] != 0; n++) @(negedge clk);
            check($sformatf("stream_drained[%0d]", g), 64'(qn[g]), 64'd0);
            @(posedge clk); #1;
        end

        // Reset with two words in flight.
        ordy[2] = 1'b1;
        iv[2] = 1'b1;
        ic[2] = 64'hA5F;
        @(posedge clk); #1;
        ic[2] = 64'h85F;
        @(posedge clk); #1;
        iv[2] = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrst_out_valid", 64'(ov[2]), 64'd0);
        rst = 1'b0;
        for (int n = 0; n < 6; n++) begin
            @(posedge clk); #1;
            check("midrst_no_stale", 64'(ov[2]), 64'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
